// File: rtl/char_slot_demux_writer_if.sv
// Producer-side valid/ready character handshake for the slot demux writer.
// The producer drives data/valid; the writer answers with a combinational ready.
interface char_slot_demux_writer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface : char_slot_demux_writer_if

// File: rtl/char_slot_demux_writer.sv
// Demultiplexes a stream of typed characters into four slot registers, with
// backspace and clear; the slots feed a downstream 4:1 character select mux.
module char_slot_demux_writer #(
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    char_slot_demux_writer_if.slave  in_if,
    input  logic                     back,
    input  logic                     clear,
    output logic [WIDTH-1:0]         slot0,
    output logic [WIDTH-1:0]         slot1,
    output logic [WIDTH-1:0]         slot2,
    output logic [WIDTH-1:0]         slot3,
    output logic [3:0]               slot_valid,
    output logic [1:0]               wr_ptr,
    output logic [2:0]               count,
    output logic                     full
);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2
    } fill_state_e;

    logic [WIDTH-1:0] slot_q [4];
    logic [WIDTH-1:0] slot_d [4];
    logic [3:0]       slot_valid_q, slot_valid_d;
    logic [1:0]       wr_ptr_q, wr_ptr_d;
    logic [2:0]       count_q, count_d;
    logic             full_q, full_d;

    fill_state_e      fill_state;
    logic             accept;
    logic             do_back;
    logic [1:0]       last_ptr;

    // Fill state is a pure function of count; there is no separate state flop.
    always_comb begin
        fill_state = ST_FILLING;
        if (count_q == 3'd0) begin
            fill_state = ST_EMPTY;
        end else if (count_q == 3'd4) begin
            fill_state = ST_FULL;
        end
    end

    assign in_if.in_ready = reset_n & ~full_q & ~back & ~clear;
    assign accept         = in_if.in_valid & in_if.in_ready;
    assign do_back        = back & (fill_state != ST_EMPTY);
    assign last_ptr       = wr_ptr_q - 2'd1;

    // NOTE: every _d signal takes its _q value first so no path leaves it
    // unassigned; a missing default here would infer a latch.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            slot_d[i] = slot_q[i];
        end
        slot_valid_d = slot_valid_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        full_d       = full_q;

        if (clear) begin
            for (int i = 0; i < 4; i++) begin
                slot_d[i] = '0;
            end
            slot_valid_d = 4'b0000;
            wr_ptr_d     = 2'd0;
            count_d      = 3'd0;
            full_d       = 1'b0;
        end else if (do_back) begin
            slot_d[last_ptr]       = '0;
            slot_valid_d[last_ptr] = 1'b0;
            wr_ptr_d               = last_ptr;
            count_d                = count_q - 3'd1;
            full_d                 = 1'b0;
        end else if (accept) begin
            slot_d[wr_ptr_q]       = in_if.in_data;
            slot_valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d               = wr_ptr_q + 2'd1;
            count_d                = count_q + 3'd1;
            full_d                 = (count_q == 3'd3);
        end
    end

    // NOTE: state flops use non-blocking assignments so every register samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the slot registers are reset too, because the downstream
            // mux shows their contents directly and must read zero after reset.
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= '0;
            end
            slot_valid_q <= 4'b0000;
            wr_ptr_q     <= 2'd0;
            count_q      <= 3'd0;
            full_q       <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= slot_d[i];
            end
            slot_valid_q <= slot_valid_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            full_q       <= full_d;
        end
    end

    assign slot0      = slot_q[0];
    assign slot1      = slot_q[1];
    assign slot2      = slot_q[2];
    assign slot3      = slot_q[3];
    assign slot_valid = slot_valid_q;
    assign wr_ptr     = wr_ptr_q;
    assign count      = count_q;
    assign full       = full_q;

endmodule : char_slot_demux_writer

// File: tb/tb_char_slot_demux_writer.sv
// Bench for char_slot_demux_writer: directed test-plan steps followed by random
// traffic, all compared against a queue-based model of the typed text.
module tb_char_slot_demux_writer;

    localparam int WIDTH = 8;

    logic             clock;
    logic             reset_n;
    logic             back;
    logic             clear;
    logic [WIDTH-1:0] slot0, slot1, slot2, slot3;
    logic [3:0]       slot_valid;
    logic [1:0]       wr_ptr;
    logic [2:0]       count;
    logic             full;

    int total;
    int bad;

    // The model: the typed characters, oldest first; slot i holds text[i].
    logic [WIDTH-1:0] text [$];

    char_slot_demux_writer_if #(.WIDTH(WIDTH)) in_if ();

    char_slot_demux_writer #(.WIDTH(WIDTH)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_if      (in_if.slave),
        .back       (back),
        .clear      (clear),
        .slot0      (slot0),
        .slot1      (slot1),
        .slot2      (slot2),
        .slot3      (slot3),
        .slot_valid (slot_valid),
        .wr_ptr     (wr_ptr),
        .count      (count),
        .full       (full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [WIDTH-1:0] exp_slot(input int i);
        return (i < text.size()) ? text[i] : '0;
    endfunction

    task automatic check_outputs(input string tag);
        int n;
        n = text.size();
        check({tag, ".slot0"}, 32'(slot0), 32'(exp_slot(0)));
        check({tag, ".slot1"}, 32'(slot1), 32'(exp_slot(1)));
        check({tag, ".slot2"}, 32'(slot2), 32'(exp_slot(2)));
        check({tag, ".slot3"}, 32'(slot3), 32'(exp_slot(3)));
        check({tag, ".slot_valid"}, 32'(slot_valid), (32'd1 << n) - 32'd1);
        check({tag, ".wr_ptr"}, 32'(wr_ptr), 32'(n % 4));
        check({tag, ".count"}, 32'(count), 32'(n));
        check({tag, ".full"}, 32'(full), 32'(n == 4));
    endtask

    // One clock cycle: drive at the falling edge, check ready mid-cycle,
    // advance the model at the rising edge, check registered outputs just after.
    task automatic step(input string tag, input logic [WIDTH-1:0] d,
                        input logic v, input logic b, input logic c);
        logic exp_ready;
        @(negedge clock);
        in_if.in_data  = d;
        in_if.in_valid = v;
        back           = b;
        clear          = c;
        exp_ready      = (text.size() < 4) && !b && !c;
        #1;
        check({tag, ".in_ready"}, 32'(in_if.in_ready), 32'(exp_ready));
        @(posedge clock);
        if (c) begin
            text.delete();
        end else if (b) begin
            if (text.size() > 0) void'(text.pop_back());
        end else if (v && exp_ready) begin
            text.push_back(d);
        end
        #1;
        check_outputs(tag);
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        reset_n        = 1'b0;
        back           = 1'b0;
        clear          = 1'b0;
        in_if.in_data  = '0;
        in_if.in_valid = 1'b0;

        // Reset state, including ready held low while in reset.
        repeat (2) @(posedge clock);
        #1;
        check("reset.in_ready", 32'(in_if.in_ready), 32'd0);
        check_outputs("reset");
        @(negedge clock);
        reset_n = 1'b1;

        // Fill with 'a'..'d', valid held high: one accept per cycle.
        for (int i = 0; i < 4; i++) step("fill", 8'h61 + 8'(i), 1'b1, 1'b0, 1'b0);
        check("fill.slot3_is_d", 32'(slot3), 32'h64);

        // Full: offered data is ignored for three cycles.
        for (int i = 0; i < 3; i++) step("full_hold", 8'h65, 1'b1, 1'b0, 1'b0);
        step("full_back", 8'h65, 1'b1, 1'b1, 1'b0);
        check("full_back.wr_ptr3", 32'(wr_ptr), 32'd3);
        step("refill", 8'h65, 1'b1, 1'b0, 1'b0);
        check("refill.slot3_is_e", 32'(slot3), 32'h65);

        // Backspace on empty is ignored; next write lands in slot0.
        step("to_empty", 8'h00, 1'b0, 1'b0, 1'b1);
        step("empty_back", 8'h00, 1'b0, 1'b1, 1'b0);
        step("write_A", 8'h41, 1'b1, 1'b0, 1'b0);
        check("write_A.slot0", 32'(slot0), 32'h41);

        // clear + back + write together: clear wins, 'z' not stored.
        step("two", 8'h42, 1'b1, 1'b0, 1'b0);
        step("clr_all", 8'h7A, 1'b1, 1'b1, 1'b1);
        check("clr_all.count", 32'(count), 32'd0);

        // back + write together: back wins, 'z' not stored.
        step("w1", 8'h31, 1'b1, 1'b0, 1'b0);
        step("w2", 8'h32, 1'b1, 1'b0, 1'b0);
        step("back_vs_write", 8'h7A, 1'b1, 1'b1, 1'b0);
        check("back_vs_write.slot1", 32'(slot1), 32'h00);

        // Asynchronous reset mid-sequence, between clock edges.
        step("pre_rst1", 8'h51, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        in_if.in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        text.delete();
        #1;
        check("async_rst.in_ready", 32'(in_if.in_ready), 32'd0);
        check_outputs("async_rst");
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        step("post_rst", 8'h77, 1'b1, 1'b0, 1'b0);
        check("post_rst.slot0", 32'(slot0), 32'h77);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            step("rand", 8'($urandom), ($urandom_range(0, 99) < 70),
                 (r < 15), (r >= 15 && r < 20));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule : tb_char_slot_demux_writer
